// File: rtl/overcooked_pkg.sv
// overcooked_pkg
// Purpose: shared types and constants for the player action path.
//   action_t   - 3-bit action code presented to the game-state engine
//   BTN_*      - bit positions inside a player's 5-bit button group
//   arb_state_t- output FSM states of the action arbiter
// Build option: ACTION_STATS_EN (used by player_input_tracker) enables
// per-player drop counters.
package overcooked_pkg;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_LEFT   = 3'd1,
        ACT_RIGHT  = 3'd2,
        ACT_UP     = 3'd3,
        ACT_DOWN   = 3'd4,
        ACT_CHOP   = 3'd5,
        ACT_PICKUP = 3'd6,
        ACT_DROP   = 3'd7
    } action_t;

    localparam int BTN_LEFT    = 0;
    localparam int BTN_RIGHT   = 1;
    localparam int BTN_UP      = 2;
    localparam int BTN_DOWN    = 3;
    localparam int BTN_CHOP    = 4;
    localparam int NUM_BTNS    = 5;
    localparam int MAX_PLAYERS = 4;

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } arb_state_t;

endpackage

// File: rtl/player_input_tracker.sv
// player_input_tracker
// Purpose: converts one player's debounced button and carry levels into at
// most one action per cycle, holds it in a one-deep pending slot until the
// arbiter consumes it, and optionally counts discarded events.
// Build option: ACTION_STATS_EN builds an 8-bit saturating drop counter;
// without it drop_count_o is tied to 0.
// Ports:
//   clock_i, reset_i  clock, asynchronous active-high reset
//   active_i          player is enabled; when low the slot is forced empty
//   btn_i[4:0]        {chop, down, up, right, left} levels
//   carry_i           carry switch level
//   clear_i           arbiter handshake completed for this player's slot
//   pending_o         slot holds an action
//   code_o            action held in the slot
//   drop_count_o      discarded-event counter (0 when stats are disabled)
module player_input_tracker
    import overcooked_pkg::*;
#(
    parameter int COOLDOWN = 10_000_000
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                active_i,
    input  logic [NUM_BTNS-1:0] btn_i,
    input  logic                carry_i,
    input  logic                clear_i,
    output logic                pending_o,
    output action_t             code_o,
    output logic [7:0]          drop_count_o
);

    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN - 1);

    logic [NUM_BTNS-1:0] btn_q, btn_prev_q;
    logic                carry_q, carry_prev_q;
    logic [CNT_W-1:0]    rpt_cnt_q, rpt_cnt_d;
    logic                pending_q, pending_d;
    action_t             code_q, code_d;

    logic [NUM_BTNS-1:0] rise;
    logic [3:0]          dir, dir_prev, dir_evt;
    logic                single_held, rpt_fire, pickup, putdown;
    logic                evt_valid, slot_busy;
    action_t             evt_code;

    // Levels are registered once before edge detection, so an input change
    // sampled at edge n becomes a pending action at edge n+1.
    assign rise     = btn_q & ~btn_prev_q;
    assign dir      = btn_q[BTN_DOWN:BTN_LEFT];
    assign dir_prev = btn_prev_q[BTN_DOWN:BTN_LEFT];
    assign pickup   = carry_q & ~carry_prev_q;
    assign putdown  = ~carry_q & carry_prev_q;

    // Auto-repeat only while exactly one direction is held and unchanged;
    // any direction edge or release restarts the count from zero.
    assign single_held = $onehot(dir) && (dir == dir_prev);
    assign rpt_fire    = single_held && (rpt_cnt_q == CNT_LAST);
    assign rpt_cnt_d   = (single_held && !rpt_fire) ? rpt_cnt_q + 1'b1 : '0;
    assign dir_evt     = rise[BTN_DOWN:BTN_LEFT] | (rpt_fire ? dir : 4'b0000);

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        evt_code = ACT_NONE;
        if (rise[BTN_CHOP])          evt_code = ACT_CHOP;
        else if (pickup)             evt_code = ACT_PICKUP;
        else if (putdown)            evt_code = ACT_DROP;
        else if (dir_evt[BTN_UP])    evt_code = ACT_UP;
        else if (dir_evt[BTN_DOWN])  evt_code = ACT_DOWN;
        else if (dir_evt[BTN_LEFT])  evt_code = ACT_LEFT;
        else if (dir_evt[BTN_RIGHT]) evt_code = ACT_RIGHT;
    end

    assign evt_valid = active_i && (evt_code != ACT_NONE);
    // A slot being consumed this cycle is free for a new event.
    assign slot_busy = pending_q && !clear_i;

    always_comb begin
        pending_d = slot_busy;
        code_d    = code_q;
        if (!active_i) begin
            pending_d = 1'b0;
        end else if (evt_valid && !slot_busy) begin
            pending_d = 1'b1;
            code_d    = evt_code;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            btn_q        <= '0;
            btn_prev_q   <= '0;
            carry_q      <= 1'b0;
            carry_prev_q <= 1'b0;
            rpt_cnt_q    <= '0;
            pending_q    <= 1'b0;
            code_q       <= ACT_NONE;
        end else begin
            btn_q        <= btn_i;
            btn_prev_q   <= btn_q;
            carry_q      <= carry_i;
            carry_prev_q <= carry_q;
            rpt_cnt_q    <= rpt_cnt_d;
            pending_q    <= pending_d;
            code_q       <= code_d;
        end
    end

    assign pending_o = pending_q;
    assign code_o    = code_q;

`ifdef ACTION_STATS_EN
    logic [7:0] drop_cnt_q;
    logic       discard, lost;

    // A cycle counts once whether the event lost priority, found the slot
    // full, or both.
    assign discard = evt_valid && slot_busy;
    assign lost    = active_i &&
                     ($countones({rise[BTN_CHOP], pickup, putdown, dir_evt}) > 1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            drop_cnt_q <= '0;
        end else if ((discard || lost) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count_o = drop_cnt_q;
`else
    assign drop_count_o = 8'd0;
`endif

endmodule

// File: rtl/player_action_arbiter.sv
// player_action_arbiter
// Purpose: shares the single game-logic action port among up to 4 players.
// Each player lane (player_input_tracker) produces actions into a one-deep
// slot; a round-robin arbiter presents one slot at a time over valid/ready.
// Build option: ACTION_STATS_EN enables per-player drop counters.
// Ports:
//   clock_in, reset_in  clock, asynchronous active-high reset
//   num_players_in      active player count minus 1
//   btn_in              5 button levels per player {chop,down,up,right,left}
//   carry_in            carry switch level per player
//   act_valid_out       action presented
//   act_ready_in        game logic accepts the presented action
//   act_player_out      player index of the presented action
//   act_code_out        action_t code of the presented action
//   pending_out         pending-slot status per player
//   drop_count_out      8-bit dropped-event counter per player
module player_action_arbiter
    import overcooked_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int COOLDOWN    = 10_000_000
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic [1:0]                  num_players_in,
    input  logic [NUM_PLAYERS*5-1:0]    btn_in,
    input  logic [NUM_PLAYERS-1:0]      carry_in,
    output logic                        act_valid_out,
    input  logic                        act_ready_in,
    output logic [1:0]                  act_player_out,
    output logic [2:0]                  act_code_out,
    output logic [NUM_PLAYERS-1:0]      pending_out,
    output logic [NUM_PLAYERS*8-1:0]    drop_count_out
);

    arb_state_t state_q;
    logic [1:0] ptr_q;
    logic       valid_q;
    logic [1:0] player_q;
    action_t    code_q;

    logic [NUM_PLAYERS-1:0] pending;
    action_t                slot_code [NUM_PLAYERS];

    logic       grant_found;
    logic [1:0] grant_idx;
    action_t    grant_code;
    logic [1:0] next_ptr;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        logic active, clear;

        assign active = (2'(i) <= num_players_in);
        // The granted slot stays occupied while presented, so a new event
        // for that player during backpressure is discarded.
        assign clear  = (state_q == ST_PRESENT) && act_ready_in && (player_q == 2'(i));

        player_input_tracker #(
            .COOLDOWN (COOLDOWN)
        ) u_tracker (
            .clock_i      (clock_in),
            .reset_i      (reset_in),
            .active_i     (active),
            .btn_i        (btn_in[i*5 +: 5]),
            .carry_i      (carry_in[i]),
            .clear_i      (clear),
            .pending_o    (pending[i]),
            .code_o       (slot_code[i]),
            .drop_count_o (drop_count_out[i*8 +: 8])
        );
    end

    // First pending player at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        grant_code  = ACT_NONE;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (!grant_found && pending[(int'(ptr_q) + k) % NUM_PLAYERS]) begin
                grant_found = 1'b1;
                grant_idx   = 2'((int'(ptr_q) + k) % NUM_PLAYERS);
                grant_code  = slot_code[(int'(ptr_q) + k) % NUM_PLAYERS];
            end
        end
    end

    assign next_ptr = (player_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : player_q + 2'd1;

    // The presented player/code are held here, not read from the slot, so a
    // player deactivated mid-present still completes its handshake.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            valid_q  <= 1'b0;
            player_q <= 2'd0;
            code_q   <= ACT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        player_q <= grant_idx;
                        code_q   <= grant_code;
                        valid_q  <= 1'b1;
                        state_q  <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (act_ready_in) begin
                        valid_q <= 1'b0;
                        ptr_q   <= next_ptr;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign act_valid_out  = valid_q;
    assign act_player_out = player_q;
    assign act_code_out   = code_q;
    assign pending_out    = pending;

endmodule

// File: tb/tb_player_action_arbiter.sv
// tb_player_action_arbiter
// Purpose: self-checking bench for player_action_arbiter with COOLDOWN=8
// and four players. A cycle-level behavioural model derives actions from the
// input history (edges, held-run lengths, priority list) and tracks slots
// and the presenter; directed scenarios add fixed expectations.
// Build option: ACTION_STATS_EN selects the expected drop counter values.
module tb_player_action_arbiter;
    import overcooked_pkg::*;

    localparam int NP = 4;
    localparam int CD = 8;

    logic             clock_in = 1'b0;
    logic             reset_in = 1'b1;
    logic [1:0]       num_players_in = 2'd3;
    logic [NP*5-1:0]  btn_in = '0;
    logic [NP-1:0]    carry_in = '0;
    logic             act_ready_in = 1'b1;
    logic             act_valid_out;
    logic [1:0]       act_player_out;
    logic [2:0]       act_code_out;
    logic [NP-1:0]    pending_out;
    logic [NP*8-1:0]  drop_count_out;

    player_action_arbiter #(
        .NUM_PLAYERS (NP),
        .COOLDOWN    (CD)
    ) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .num_players_in (num_players_in),
        .btn_in         (btn_in),
        .carry_in       (carry_in),
        .act_valid_out  (act_valid_out),
        .act_ready_in   (act_ready_in),
        .act_player_out (act_player_out),
        .act_code_out   (act_code_out),
        .pending_out    (pending_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clock_in = ~clock_in;

    wire [41:0] dut_vec = {act_valid_out, act_player_out, act_code_out, pending_out, drop_count_out};

    int vectors = 0;
    int miscompares = 0;

    // Model state: two most recent input samples, run length of the current
    // single-direction hold, slot contents, drop tallies, presenter.
    logic [4:0] h1_btn [NP];
    logic [4:0] h2_btn [NP];
    logic       h1_car [NP];
    logic       h2_car [NP];
    int         h1_run [NP];
    bit         slot_full [NP];
    int         slot_code [NP];
    int         drops [NP];
    bit         busy;
    int         gp, gc, ptr;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            h1_btn[p] = '0; h2_btn[p] = '0; h1_car[p] = 1'b0; h2_car[p] = 1'b0;
            h1_run[p] = 0; slot_full[p] = 1'b0; slot_code[p] = 0; drops[p] = 0;
        end
        busy = 1'b0; gp = 0; gc = 0; ptr = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit         cleared [NP];
        int         cand[$];
        logic [4:0] rise;
        logic [3:0] dir, ndir, rep;
        bit         drop, busy_slot;
        for (int p = 0; p < NP; p++) cleared[p] = 1'b0;
        if (busy) begin
            if (act_ready_in) begin
                cleared[gp] = 1'b1;
                ptr = (gp + 1) % NP;
                busy = 1'b0;
            end
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (!busy && slot_full[(ptr + k) % NP]) begin
                    busy = 1'b1;
                    gp = (ptr + k) % NP;
                    gc = slot_code[gp];
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            cand.delete();
            rise = h1_btn[p] & ~h2_btn[p];
            dir  = h1_btn[p][3:0];
            rep  = ($countones(dir) == 1 && h1_run[p] > 1 && (h1_run[p] - 1) % CD == 0) ? dir : 4'b0;
            if (rise[BTN_CHOP]) cand.push_back(5);
            if (h1_car[p] && !h2_car[p]) cand.push_back(6);
            if (!h1_car[p] && h2_car[p]) cand.push_back(7);
            if (rise[BTN_UP]    || rep[BTN_UP])    cand.push_back(3);
            if (rise[BTN_DOWN]  || rep[BTN_DOWN])  cand.push_back(4);
            if (rise[BTN_LEFT]  || rep[BTN_LEFT])  cand.push_back(1);
            if (rise[BTN_RIGHT] || rep[BTN_RIGHT]) cand.push_back(2);
            if (p > int'(num_players_in)) begin
                slot_full[p] = 1'b0;
            end else begin
                drop = (cand.size() > 1);
                busy_slot = slot_full[p] && !cleared[p];
                if (cand.size() > 0) begin
                    if (busy_slot) drop = 1'b1;
                    else begin
                        slot_full[p] = 1'b1;
                        slot_code[p] = cand[0];
                    end
                end else if (cleared[p]) begin
                    slot_full[p] = 1'b0;
                end
                if (drop && drops[p] < 255) drops[p]++;
            end
            ndir = btn_in[p*5 +: 4];
            if ($countones(ndir) == 1 && ndir == dir) h1_run[p]++;
            else h1_run[p] = ($countones(ndir) == 1) ? 1 : 0;
            h2_btn[p] = h1_btn[p];
            h1_btn[p] = btn_in[p*5 +: 5];
            h2_car[p] = h1_car[p];
            h1_car[p] = carry_in[p];
        end
    endtask

    function automatic logic [41:0] exp_vec();
        logic [3:0]  pend;
        logic [31:0] dc;
        pend = '0;
        dc   = '0;
        for (int p = 0; p < NP; p++) begin
            pend[p] = slot_full[p];
`ifdef ACTION_STATS_EN
            dc[p*8 +: 8] = 8'(drops[p]);
`endif
        end
        return {busy, 2'(gp), 3'(gc), pend, dc};
    endfunction

    // Advance one edge and leave the bench 1 time unit after it.
    task automatic step();
        @(posedge clock_in);
        model_edge();
        #1;
    endtask

    task automatic set_btn(input int p, input int b, input logic v);
        btn_in[p*5 + b] = v;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        btn_in = '0;
        carry_in = '0;
        act_ready_in = 1'b1;
        num_players_in = 2'd3;
        model_reset();
        repeat (2) @(posedge clock_in);
        #1 reset_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (dut_vec !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", dut_vec);
        end
    endtask

    task automatic test_single_press();
        int nval = 0;
        do_reset();
        set_btn(0, BTN_LEFT, 1'b1);
        for (int c = 0; c < 16; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_press cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 1) begin
                vectors++;
                if (act_valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_press_early: valid %b want 0", act_valid_out);
                end
            end
            if (c == 2) begin
                vectors++;
                if ({act_valid_out, act_player_out, act_code_out} !== {1'b1, 2'd0, 3'd1}) begin
                    miscompares++;
                    $display("FAIL single_press_latency: got %b/%0d/%0d want 1/0/1",
                             act_valid_out, act_player_out, act_code_out);
                end
                set_btn(0, BTN_LEFT, 1'b0);
            end
            if (act_valid_out) nval++;
        end
        vectors++;
        if (nval !== 1) begin
            miscompares++;
            $display("FAIL single_press_count: got %0d actions want 1", nval);
        end
    endtask

    task automatic test_round_robin();
        int  order[$];
        bit  seen = 1'b0;
        do_reset();
        for (int p = 0; p < NP; p++) set_btn(p, BTN_CHOP, 1'b1);
        for (int c = 0; c < 14; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL round_robin cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 0) btn_in = '0;
            if (act_valid_out) begin
                order.push_back(int'(act_player_out));
                vectors++;
                if (act_code_out !== 3'd5) begin
                    miscompares++;
                    $display("FAIL round_robin_code: got %0d want 5", act_code_out);
                end
            end
        end
        vectors++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
            miscompares++;
            $display("FAIL round_robin_order: got %p want 0,1,2,3", order);
        end
        // Pointer wrapped to 0: with players 3 and 0 pending, 0 wins.
        set_btn(0, BTN_CHOP, 1'b1);
        set_btn(3, BTN_CHOP, 1'b1);
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL round_robin_wrap cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 0) btn_in = '0;
            if (act_valid_out) seen = 1'b1;
        end
        vectors++;
        if (!seen || act_player_out !== 2'd0) begin
            miscompares++;
            $display("FAIL round_robin_ptr: seen %b player %0d want 0", seen, act_player_out);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] held;
        logic [7:0] exp_drop;
        held = '0;
`ifdef ACTION_STATS_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif
        do_reset();
        act_ready_in = 1'b0;
        set_btn(1, BTN_RIGHT, 1'b1);
        for (int c = 0; c < 18; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL backpressure cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 0) set_btn(1, BTN_RIGHT, 1'b0);
            if (c == 4) set_btn(1, BTN_RIGHT, 1'b1);
            if (c == 6) set_btn(1, BTN_RIGHT, 1'b0);
            if (c == 2) held = {act_valid_out, act_player_out, act_code_out};
            if (c >= 2 && c <= 11) begin
                vectors++;
                if ({act_valid_out, act_player_out, act_code_out} !== {1'b1, 2'd1, 3'd2} || pending_out[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL backpressure_stable cyc %0d: got %b pend %b want 100010 pend 1",
                             c, {act_valid_out, act_player_out, act_code_out}, pending_out);
                end
            end
            if (c == 11) act_ready_in = 1'b1;
            if (c == 12) begin
                vectors++;
                if (act_valid_out !== 1'b0 || pending_out !== 4'b0 || held !== {1'b1, 2'd1, 3'd2}) begin
                    miscompares++;
                    $display("FAIL backpressure_release: valid %b pend %b first %b", act_valid_out, pending_out, held);
                end
                vectors++;
                if (drop_count_out[15:8] !== exp_drop) begin
                    miscompares++;
                    $display("FAIL backpressure_drop: got %0d want %0d", drop_count_out[15:8], exp_drop);
                end
            end
        end
    endtask

    task automatic test_auto_repeat();
        int n_up = 0;
        int n_combo = 0;
        do_reset();
        set_btn(2, BTN_UP, 1'b1);
        for (int c = 0; c < 30; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL auto_repeat cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 19) set_btn(2, BTN_UP, 1'b0);
            if (act_valid_out && act_player_out == 2'd2 && act_code_out == 3'd3) n_up++;
        end
        vectors++;
        if (n_up !== 3) begin
            miscompares++;
            $display("FAIL auto_repeat_count: got %0d want 3", n_up);
        end
        set_btn(2, BTN_UP, 1'b1);
        set_btn(2, BTN_LEFT, 1'b1);
        for (int c = 0; c < 30; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL auto_repeat_combo cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 19) btn_in = '0;
            if (act_valid_out) n_combo++;
        end
        vectors++;
        if (n_combo !== 1) begin
            miscompares++;
            $display("FAIL auto_repeat_combo_count: got %0d want 1", n_combo);
        end
    endtask

    task automatic test_carry_inactive();
        int codes[$];
        int n_inact = 0;
        do_reset();
        num_players_in = 2'd0;
        carry_in[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL inactive cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (act_valid_out || pending_out != 4'b0) n_inact++;
        end
        vectors++;
        if (n_inact !== 0) begin
            miscompares++;
            $display("FAIL inactive_quiet: got %0d active cycles want 0", n_inact);
        end
        carry_in[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL carry cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 3) carry_in[0] = 1'b0;
            if (act_valid_out) codes.push_back(int'(act_code_out));
        end
        vectors++;
        if (codes.size() != 2 || codes[0] != 6 || codes[1] != 7) begin
            miscompares++;
            $display("FAIL carry_codes: got %p want 6,7", codes);
        end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        do_reset();
        set_btn(2, BTN_CHOP, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL async_pre cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 0) btn_in = '0;
        end
        act_ready_in = 1'b0;
        set_btn(1, BTN_CHOP, 1'b1);
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL async_setup cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 0) btn_in = '0;
            if (act_valid_out) seen = 1'b1;
        end
        vectors++;
        if (!seen || act_player_out !== 2'd1) begin
            miscompares++;
            $display("FAIL async_present: seen %b player %0d want 1", seen, act_player_out);
        end
        #3 reset_in = 1'b1;
        #1;
        vectors++;
        if (act_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_valid: got %b want 0", act_valid_out);
        end
        vectors++;
        if (pending_out !== 4'b0) begin
            miscompares++;
            $display("FAIL async_pending: got %b want 0", pending_out);
        end
        model_reset();
        @(posedge clock_in);
        #1 reset_in = 1'b0;
        act_ready_in = 1'b1;
        set_btn(0, BTN_CHOP, 1'b1);
        set_btn(3, BTN_CHOP, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL async_post cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
            if (c == 0) btn_in = '0;
            if (act_valid_out) seen = 1'b1;
        end
        vectors++;
        if (!seen || act_player_out !== 2'd0) begin
            miscompares++;
            $display("FAIL async_ptr: seen %b player %0d want 0", seen, act_player_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NP*5; b++)
                if ($urandom_range(0, 11) == 0) btn_in[b] = ~btn_in[b];
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 15) == 0) carry_in[p] = ~carry_in[p];
            act_ready_in = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) num_players_in = 2'($urandom_range(0, 3));
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h model %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_round_robin();
        test_backpressure();
        test_auto_repeat();
        test_carry_inactive();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
